// File: rtl/peripheral_biu_verilog_pkg.sv
// Shared definitions for the generic TL slave BFM: response codes, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package peripheral_biu_verilog_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Width of the read-latency down-counter (RD_LATENCY range 0..15).
    localparam int CNT_W = 4;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_WAIT = 2'b01,
        R_DATA = 2'b10
    } r_state_e;

endpackage

// File: rtl/peripheral_bfm_slave_ram_tl.sv
// Word-wide RAM with one byte-enabled write port and one registered read port.
// Latency: read data appears the cycle after re is sampled; writes land on the edge.
// Backpressure: none; the read register holds its value until the next re.
//
// Ports: clk/rst (rst clears only the read register, never the array),
//        we/waddr/wdata/wstrb write port, re/raddr/rdata read port.
module peripheral_bfm_slave_ram_tl #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we && wstrb[b]) begin
                mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Read samples the pre-edge contents, so a write on the same edge is not seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/peripheral_bfm_slave_generic_tl.sv
// Single-beat AXI-like slave BFM backed by a DEPTH x 32 byte-enabled RAM.
// Latency: bvalid the cycle after both AW and W are in; rvalid RD_LATENCY+1 cycles after AR.
// Backpressure: b/r outputs hold stable until bready/rready; no new AW/W/AR accepted meanwhile.
//
// Ports: aclk/areset (sync, active-high); AW (awid, awadr, awvalid, awready),
//        W (wrdata, wstrb, wvalid, wready), B (bid, bresp, bvalid, bready),
//        AR (arid, araddr, arvalid, arready), R (rid, rdata, rresp, rlast, rvalid, rready).
// Build option: PERIPHERAL_BFM_SLAVE_RANGE_ERROR_EN makes word addresses >= DEPTH return
//        SLVERR (write dropped, read data 0); otherwise addresses wrap modulo DEPTH.
module peripheral_bfm_slave_generic_tl
    import peripheral_biu_verilog_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int RD_LATENCY = 2
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [3:0]  awid,
    input  logic [31:0] awadr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wrdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);

    localparam int               AW      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] RD_LAT  = CNT_W'(RD_LATENCY);
    localparam logic [29:0]      DEPTH_W = 30'(DEPTH);

    // Address bits below the word and, when wrapping, above the index are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{awadr[1:0], araddr[1:0], awadr[31:AW+2], araddr[31:AW+2]};

    logic aw_oor_in, ar_oor_in;
`ifdef PERIPHERAL_BFM_SLAVE_RANGE_ERROR_EN
    assign aw_oor_in = (awadr[31:2] >= DEPTH_W);
    assign ar_oor_in = (araddr[31:2] >= DEPTH_W);
`else
    logic unused_depth_w;
    assign unused_depth_w = ^DEPTH_W;
    assign aw_oor_in = 1'b0;
    assign ar_oor_in = 1'b0;
`endif

    // ---------------- write channel ----------------
    w_state_e      w_state_q;
    logic          aw_held_q, w_held_q, aw_oor_q;
    logic [3:0]    awid_q, wstrb_q, bid_q;
    logic [AW-1:0] awidx_q;
    logic [31:0]   wdata_q;
    logic          bvalid_q;
    logic [1:0]    bresp_q;

    logic          aw_hs, w_hs, commit, cur_oor;
    logic [3:0]    cur_awid, cur_wstrb;
    logic [AW-1:0] cur_awidx;
    logic [31:0]   cur_wdata;

    assign awready = (w_state_q == W_IDLE) && !aw_held_q;
    assign wready  = (w_state_q == W_IDLE) && !w_held_q;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    // A beat arriving this cycle counts as held, so a same-cycle AW+W commits immediately.
    assign commit    = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign cur_awid  = aw_held_q ? awid_q   : awid;
    assign cur_awidx = aw_held_q ? awidx_q  : awadr[AW+1:2];
    assign cur_oor   = aw_held_q ? aw_oor_q : aw_oor_in;
    assign cur_wdata = w_held_q  ? wdata_q  : wrdata;
    assign cur_wstrb = w_held_q  ? wstrb_q  : wstrb;

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_oor_q  <= 1'b0;
            awid_q    <= '0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (commit) begin
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bid_q     <= cur_awid;
                        bresp_q   <= cur_oor ? RESP_SLVERR : RESP_OKAY;
                        w_state_q <= W_RESP;
                    end else begin
                        if (aw_hs) begin
                            aw_held_q <= 1'b1;
                            awid_q    <= awid;
                            awidx_q   <= awadr[AW+1:2];
                            aw_oor_q  <= aw_oor_in;
                        end
                        if (w_hs) begin
                            w_held_q <= 1'b1;
                            wdata_q  <= wrdata;
                            wstrb_q  <= wstrb;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_q  <= 1'b0;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    assign bvalid = bvalid_q;
    assign bid    = bid_q;
    assign bresp  = bresp_q;

    // ---------------- read channel ----------------
    r_state_e         r_state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    raddr_q;
    logic             rerr_q, rvalid_q;
    logic [3:0]       rid_q;
    logic [1:0]       rresp_q;
    logic             ram_re;
    logic [AW-1:0]    ram_raddr;
    logic [31:0]      ram_rdata;

    assign arready = (r_state_q == R_IDLE);
    assign cnt_d   = cnt_q - 1'b1;

    // The RAM samples on the edge that enters R_DATA; with zero latency that is the AR edge.
    assign ram_re = !areset &&
                    (((r_state_q == R_IDLE) && arvalid && (RD_LATENCY == 0)) ||
                     ((r_state_q == R_WAIT) && (cnt_d == '0)));
    assign ram_raddr = (r_state_q == R_IDLE) ? araddr[AW+1:2] : raddr_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_q <= R_IDLE;
            cnt_q     <= '0;
            raddr_q   <= '0;
            rerr_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (arvalid) begin
                        rid_q   <= arid;
                        raddr_q <= araddr[AW+1:2];
                        rerr_q  <= ar_oor_in;
                        cnt_q   <= RD_LAT;
                        if (RD_LATENCY == 0) begin
                            rvalid_q  <= 1'b1;
                            rresp_q   <= ar_oor_in ? RESP_SLVERR : RESP_OKAY;
                            r_state_q <= R_DATA;
                        end else begin
                            r_state_q <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == '0) begin
                        rvalid_q  <= 1'b1;
                        rresp_q   <= rerr_q ? RESP_SLVERR : RESP_OKAY;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rvalid_q  <= 1'b0;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    peripheral_bfm_slave_ram_tl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (aclk),
        .rst   (areset),
        .we    (commit && !cur_oor && !areset),
        .waddr (cur_awidx),
        .wdata (cur_wdata),
        .wstrb (cur_wstrb),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Error responses carry zero data rather than whatever the wrapped index held.
    assign rdata  = (rresp_q == RESP_SLVERR) ? 32'h0 : ram_rdata;
    assign rvalid = rvalid_q;
    assign rlast  = rvalid_q;
    assign rid    = rid_q;
    assign rresp  = rresp_q;

endmodule

// File: tb/tb_peripheral_bfm_slave_generic_tl.sv
// Randomized + directed bench with a word-array reference model and response scoreboards.
// Latency: checks bvalid one cycle after the last of AW/W, rvalid RD_LATENCY+1 after AR.
// Backpressure: holds bready/rready low for a while and checks outputs stay put.
module tb_peripheral_bfm_slave_generic_tl;

    localparam int DEPTH      = 16;
    localparam int RD_LATENCY = 2;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [3:0]  awid = '0, wstrb = '0, arid = '0;
    logic [31:0] awadr = '0, wrdata = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rlast, rvalid;
    logic [3:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    always #5 aclk = ~aclk;

    peripheral_bfm_slave_generic_tl #(.DEPTH(DEPTH), .RD_LATENCY(RD_LATENCY)) dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awadr(awadr), .awvalid(awvalid), .awready(awready),
        .wrdata(wrdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; } r_exp_t;

    b_exp_t      bq[$];
    r_exp_t      rq[$];
    logic [31:0] model_mem [DEPTH];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: word array indexed by addr[31:2], wrapping or erroring by build option.
    function automatic b_exp_t model_write(input logic [31:0] addr, input logic [31:0] data,
                                           input logic [3:0] strb, input logic [3:0] id);
        b_exp_t e;
        int     w, idx;
        w      = int'(addr[31:2]);
        e.id   = id;
        e.resp = OKAY;
`ifdef PERIPHERAL_BFM_SLAVE_RANGE_ERROR_EN
        if (w >= DEPTH) begin
            e.resp = SLVERR;
            return e;
        end
`endif
        idx = w % DEPTH;
        for (int b = 0; b < 4; b++)
            if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
        return e;
    endfunction

    function automatic r_exp_t model_read(input logic [31:0] addr, input logic [3:0] id);
        r_exp_t e;
        int     w;
        w      = int'(addr[31:2]);
        e.id   = id;
        e.resp = OKAY;
`ifdef PERIPHERAL_BFM_SLAVE_RANGE_ERROR_EN
        if (w >= DEPTH) begin
            e.resp = SLVERR;
            e.data = 32'h0;
            return e;
        end
`endif
        e.data = model_mem[w % DEPTH];
        return e;
    endfunction

    // Monitors: pop and compare whenever a response handshake is about to happen.
    initial forever begin
        @(negedge aclk);
        if (bvalid && bready) begin
            if (bq.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
            else begin
                b_exp_t e;
                e = bq.pop_front();
                chk("bid", 32'(bid), 32'(e.id));
                chk("bresp", 32'(bresp), 32'(e.resp));
            end
        end
        if (rvalid && rready) begin
            if (rq.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
            else begin
                r_exp_t e;
                e = rq.pop_front();
                chk("rid", 32'(rid), 32'(e.id));
                chk("rdata", rdata, e.data);
                chk("rresp", 32'(rresp), 32'(e.resp));
                chk("rlast", 32'(rlast), 32'd1);
            end
        end
    end

    // lead > 0: W presented that many cycles before AW; lead < 0: AW first.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [3:0] id, input int lead, input int b_hold);
        b_exp_t e;
        int  aw_start, w_start, n, aw_n, w_n, held;
        bit  aw_f, w_f, b_f, aw_done, w_done, b_done;
        e = model_write(addr, data, strb, id);
        bq.push_back(e);
        aw_start = (lead > 0) ? lead : 0;
        w_start  = (lead < 0) ? -lead : 0;
        awid = id; awadr = addr; wrdata = data; wstrb = strb;
        awvalid = (aw_start == 0);
        wvalid  = (w_start == 0);
        bready  = (b_hold == 0);
        aw_done = 0; w_done = 0; b_done = 0; n = 0; aw_n = 0; w_n = 0; held = 0;
        while (!b_done && n < 200) begin
            @(negedge aclk);
            if (w_done && !aw_done) chk("wready_drop", 32'(wready), 32'd0);
            if (aw_done && !w_done) chk("awready_drop", 32'(awready), 32'd0);
            if (aw_done && w_done && n == ((aw_n > w_n) ? aw_n : w_n) + 1)
                chk("bvalid_latency", 32'(bvalid), 32'd1);
            if (bvalid && !bready) begin
                chk("bhold_bid", 32'(bid), 32'(e.id));
                chk("bhold_bresp", 32'(bresp), 32'(e.resp));
                chk("bhold_awready", 32'(awready), 32'd0);
                held++;
            end
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            b_f  = bvalid && bready;
            @(posedge aclk); #1;
            if (aw_f) begin awvalid = 0; aw_done = 1; aw_n = n; end
            if (w_f)  begin wvalid = 0;  w_done = 1;  w_n = n;  end
            if (b_f) begin b_done = 1; bready = 0; end
            else if (held >= b_hold && held > 0) bready = 1;
            n++;
            if (!aw_done && n >= aw_start) awvalid = 1;
            if (!w_done && n >= w_start) wvalid = 1;
        end
        if (!b_done) begin
            chk("write_timeout", 32'd1, 32'd0);
            awvalid = 0; wvalid = 0; bready = 0;
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input int r_hold);
        r_exp_t e;
        int  n, k, held;
        bit  fired, seen, ar_f, r_f, done;
        e = model_read(addr, id);
        rq.push_back(e);
        arid = id; araddr = addr; arvalid = 1;
        rready = (r_hold == 0);
        n = 0; k = 0; held = 0; fired = 0; seen = 0; done = 0;
        while (!done && n < 200) begin
            @(negedge aclk);
            if (fired) begin
                k++;
                if (!seen && rvalid) begin
                    seen = 1;
                    chk("rvalid_latency", 32'(k), 32'(RD_LATENCY + 1));
                end
            end
            if (rvalid && !rready) begin
                chk("rhold_rid", 32'(rid), 32'(e.id));
                chk("rhold_rdata", rdata, e.data);
                chk("rhold_rresp", 32'(rresp), 32'(e.resp));
                chk("rhold_arready", 32'(arready), 32'd0);
                held++;
            end
            ar_f = arvalid && arready;
            r_f  = rvalid && rready;
            @(posedge aclk); #1;
            if (ar_f) begin arvalid = 0; fired = 1; end
            if (r_f) begin done = 1; rready = 0; end
            else if (seen && held >= r_hold) rready = 1;
            n++;
        end
        if (!done) begin
            chk("read_timeout", 32'd1, 32'd0);
            arvalid = 0; rready = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int lim;
        repeat (3) @(posedge aclk);
        #1 areset = 0;
        @(negedge aclk);
        chk("rst_awready", 32'(awready), 32'd1);
        chk("rst_wready", 32'(wready), 32'd1);
        chk("rst_arready", 32'(arready), 32'd1);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rlast", 32'(rlast), 32'd0);
        chk("rst_ids", 32'({bid, rid}), 32'd0);
        chk("rst_resps", 32'({bresp, rresp}), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(posedge aclk); #1;

        // Give every word a known value first.
        for (int i = 0; i < DEPTH; i++)
            do_write(32'(i * 4), $urandom, 4'hF, 4'($urandom), $urandom_range(0, 4) - 2, 0);

        do_write(32'h10, 32'hDEADBEEF, 4'hF, 4'h3, 0, 0);
        do_read(32'h10, 4'h5, 0);
        do_write(32'h20, 32'h11223344, 4'hF, 4'h6, 3, 0);
        do_read(32'h20, 4'h7, 0);
        do_write(32'h20, 32'h000000AA, 4'h1, 4'h8, 0, 0);
        do_read(32'h20, 4'h9, 0);
        do_write(32'h24, 32'h55667788, 4'h0, 4'hA, -2, 0);
        do_read(32'h24, 4'hB, 0);
        do_write(32'h30, 32'hA5A5A5A5, 4'hF, 4'hC, 0, 5);
        do_read(32'h30, 4'hD, 5);
        do_write(32'h4, 32'h12345678, 4'hF, 4'h1, 0, 0);
        do_write(32'((DEPTH + 1) * 4), 32'hCAFEF00D, 4'hF, 4'h2, 1, 0);
        do_read(32'h4, 4'h3, 0);
        do_read(32'((DEPTH + 1) * 4), 4'h4, 0);

        // Reset while the read is waiting out its latency.
        arid = 4'hE; araddr = 32'h10; arvalid = 1;
        lim = 0;
        while (!arready && lim < 20) begin @(posedge aclk); #1; lim++; end
        @(posedge aclk); #1;
        arvalid = 0;
        areset = 1;
        @(posedge aclk); #1;
        areset = 0;
        @(negedge aclk);
        chk("rstmid_arready", 32'(arready), 32'd1);
        chk("rstmid_rvalid", 32'(rvalid), 32'd0);
        for (int i = 0; i < RD_LATENCY + 2; i++) begin
            @(negedge aclk);
            chk("rstmid_rvalid_quiet", 32'(rvalid), 32'd0);
        end
        @(posedge aclk); #1;
        do_read(32'h10, 4'hF, 0);
        do_read(32'h20, 4'h0, 0);

        // Random traffic, including stray byte offsets and addresses beyond DEPTH.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 3) == 0) a = $urandom;
            else a = {26'(0), 4'($urandom_range(0, DEPTH - 1)), 2'($urandom)} + ($urandom_range(0, 1) * DEPTH * 4);
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom), 4'($urandom), $urandom_range(0, 6) - 3, $urandom_range(0, 2));
            else
                do_read(a, 4'($urandom), $urandom_range(0, 2));
        end

        repeat (3) @(posedge aclk);
        chk("bq_drained", 32'(bq.size()), 32'd0);
        chk("rq_drained", 32'(rq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
